// File: rtl/riscv_control_unit_pkg.sv
// Shared decode constants for the RV32I single-cycle control unit.
package riscv_pkg;

  // Supported major opcodes (instr[6:0]).
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU operation select driven to the datapath.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Immediate format select.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Writeback source select.
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Class of ALU work requested by the main decoder; 2'b11 is never produced.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  // Bundle of main-decoder outputs.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    aluop_e     alu_op;
    logic       jump;
    logic       illegal;
  } main_ctrl_t;

endpackage

// File: rtl/riscv_control_unit_if.sv
// Instruction fields in, datapath controls out.
interface riscv_control_unit_if;
  logic [6:0] Opcode;
  logic [2:0] funct3;
  logic       funct7;
  logic       zero;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic       ALUSrc;
  logic       MemWrite;
  logic [1:0] ResultSrc;
  logic       Branch;
  logic       Jump;
  logic       PCSrc;
  logic       IllegalOp;
  logic       IllegalSticky;

  // Fetch/datapath side: supplies instruction fields, consumes controls.
  modport master (
    output Opcode, funct3, funct7, zero,
    input  ALUControl, ImmSrc, RegWrite, ALUSrc, MemWrite, ResultSrc,
           Branch, Jump, PCSrc, IllegalOp, IllegalSticky
  );

  // Control unit side.
  modport slave (
    input  Opcode, funct3, funct7, zero,
    output ALUControl, ImmSrc, RegWrite, ALUSrc, MemWrite, ResultSrc,
           Branch, Jump, PCSrc, IllegalOp, IllegalSticky
  );
endinterface

// File: rtl/riscv_control_unit_alu_decoder.sv
// ALU decoder: maps ALUOp plus funct fields onto an ALU operation.
module riscv_alu_decoder
  import riscv_pkg::*;
(
  input  aluop_e     alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7,
  output logic [2:0] alu_control
);

  // Select ALU operation; only R-type with funct7 set turns funct3=000 into sub.
  always_comb begin
    // NOTE: default assigned first so every path drives alu_control and no latch is inferred.
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 && funct7) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_control_unit.sv
// RV32I control unit: main decoder, PC select and sticky illegal-opcode flag.
module riscv_control_unit
  import riscv_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  riscv_control_unit_if.slave cu
);

  main_ctrl_t ctrl;
  logic [2:0] alu_control;
  logic       illegal_sticky;

  // Main decoder; unsupported opcodes drive every control low and flag illegal.
  always_comb begin
    ctrl = '{reg_write: 1'b0, imm_src: IMM_I, alu_src: 1'b0, mem_write: 1'b0,
             result_src: RES_ALU, branch: 1'b0, alu_op: ALUOP_ADD, jump: 1'b0,
             illegal: 1'b0};
    case (cu.Opcode)
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
      end
      OP_STORE: begin
        ctrl.imm_src    = IMM_S;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_write  = 1'b1;
      end
      OP_RTYPE: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_op     = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        ctrl.imm_src    = IMM_B;
        ctrl.branch     = 1'b1;
        ctrl.alu_op     = ALUOP_SUB;
      end
      OP_ITYPE: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALUOP_FUNCT;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.imm_src    = IMM_J;
        ctrl.result_src = RES_PC4;
        ctrl.jump       = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

  riscv_alu_decoder u_alu_decoder (
    .alu_op      (ctrl.alu_op),
    .funct3      (cu.funct3),
    .op5         (cu.Opcode[5]),
    .funct7      (cu.funct7),
    .alu_control (alu_control)
  );

  // Sticky illegal flag: set on any clocked illegal opcode, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_sticky <= 1'b0;
    end else begin
      // NOTE: non-blocking so the flag updates as a true register at the clock edge.
      illegal_sticky <= illegal_sticky | ctrl.illegal;
    end
  end

  assign cu.ALUControl    = alu_control;
  assign cu.ImmSrc        = ctrl.imm_src;
  assign cu.RegWrite      = ctrl.reg_write;
  assign cu.ALUSrc        = ctrl.alu_src;
  assign cu.MemWrite      = ctrl.mem_write;
  assign cu.ResultSrc     = ctrl.result_src;
  assign cu.Branch        = ctrl.branch;
  assign cu.Jump          = ctrl.jump;
  assign cu.PCSrc         = (ctrl.branch & cu.zero) | ctrl.jump;
  assign cu.IllegalOp     = ctrl.illegal;
  assign cu.IllegalSticky = illegal_sticky;

endmodule

// File: tb/tb_riscv_control_unit.sv
// Directed scoreboard bench for riscv_control_unit.
module tb_riscv_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  riscv_control_unit_if cu_if ();

  riscv_control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cu    (cu_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic [1:0] imm;
    logic       asrc;
    logic       mw;
    logic [1:0] res;
    logic       br;
    logic       jmp;
    logic [2:0] aluc;
    logic       pcs;
    logic       ill;
    logic       stk;
  } exp_t;

  typedef struct {
    string tag;
    exp_t  e;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(logic rw, logic [1:0] imm, logic asrc, logic mw,
                              logic [1:0] res, logic br, logic jmp, logic [2:0] aluc,
                              logic pcs, logic ill, logic stk);
    exp_t e;
    e = '{rw: rw, imm: imm, asrc: asrc, mw: mw, res: res, br: br, jmp: jmp,
          aluc: aluc, pcs: pcs, ill: ill, stk: stk};
    return e;
  endfunction

  task automatic check(string name, logic [2:0] act, logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Drive one vector just after a posedge and queue its expected response.
  task automatic apply(string tag, logic rst, logic [6:0] op, logic [2:0] f3,
                       logic f7, logic z, exp_t e);
    sb_entry_t s;
    @(posedge clk);
    #1;
    rst_n        = rst;
    cu_if.Opcode = op;
    cu_if.funct3 = f3;
    cu_if.funct7 = f7;
    cu_if.zero   = z;
    s.tag = tag;
    s.e   = e;
    sb_q.push_back(s);
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on each negedge.
  initial begin
    sb_entry_t s;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        s = sb_q.pop_front();
        check({s.tag, ".RegWrite"},      {2'b0, cu_if.RegWrite},      {2'b0, s.e.rw});
        check({s.tag, ".ImmSrc"},        {1'b0, cu_if.ImmSrc},        {1'b0, s.e.imm});
        check({s.tag, ".ALUSrc"},        {2'b0, cu_if.ALUSrc},        {2'b0, s.e.asrc});
        check({s.tag, ".MemWrite"},      {2'b0, cu_if.MemWrite},      {2'b0, s.e.mw});
        check({s.tag, ".ResultSrc"},     {1'b0, cu_if.ResultSrc},     {1'b0, s.e.res});
        check({s.tag, ".Branch"},        {2'b0, cu_if.Branch},        {2'b0, s.e.br});
        check({s.tag, ".Jump"},          {2'b0, cu_if.Jump},          {2'b0, s.e.jmp});
        check({s.tag, ".ALUControl"},    cu_if.ALUControl,            s.e.aluc);
        check({s.tag, ".PCSrc"},         {2'b0, cu_if.PCSrc},         {2'b0, s.e.pcs});
        check({s.tag, ".IllegalOp"},     {2'b0, cu_if.IllegalOp},     {2'b0, s.e.ill});
        check({s.tag, ".IllegalSticky"}, {2'b0, cu_if.IllegalSticky}, {2'b0, s.e.stk});
      end
    end
  end

  // Stimulus: directed vectors with hand-derived expectations.
  initial begin
    cu_if.Opcode = 7'b0110011;
    cu_if.funct3 = 3'b000;
    cu_if.funct7 = 1'b0;
    cu_if.zero   = 1'b0;
    //                                                    rw imm    as mw res   br j  aluc    pc il st
    apply("reset",    1'b0, 7'b0110011, 3'b000, 1'b0, 1'b0, mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0));
    apply("lw",       1'b1, 7'b0000011, 3'b101, 1'b1, 1'b0, mk(1, 2'b00, 1, 0, 2'b01, 0, 0, 3'b000, 0, 0, 0));
    apply("lw_z1",    1'b1, 7'b0000011, 3'b010, 1'b0, 1'b1, mk(1, 2'b00, 1, 0, 2'b01, 0, 0, 3'b000, 0, 0, 0));
    apply("sw",       1'b1, 7'b0100011, 3'b110, 1'b0, 1'b0, mk(0, 2'b01, 1, 1, 2'b00, 0, 0, 3'b000, 0, 0, 0));
    apply("r_or",     1'b1, 7'b0110011, 3'b110, 1'b1, 1'b0, mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 3'b011, 0, 0, 0));
    apply("r_sub",    1'b1, 7'b0110011, 3'b000, 1'b1, 1'b0, mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 3'b001, 0, 0, 0));
    apply("r_add",    1'b1, 7'b0110011, 3'b000, 1'b0, 1'b0, mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0));
    apply("r_slt",    1'b1, 7'b0110011, 3'b010, 1'b0, 1'b0, mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 3'b101, 0, 0, 0));
    apply("r_and",    1'b1, 7'b0110011, 3'b111, 1'b0, 1'b0, mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 3'b010, 0, 0, 0));
    apply("r_f3_001", 1'b1, 7'b0110011, 3'b001, 1'b1, 1'b0, mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0));
    apply("beq_z0",   1'b1, 7'b1100011, 3'b111, 1'b0, 1'b0, mk(0, 2'b10, 0, 0, 2'b00, 1, 0, 3'b001, 0, 0, 0));
    apply("beq_z1",   1'b1, 7'b1100011, 3'b111, 1'b0, 1'b1, mk(0, 2'b10, 0, 0, 2'b00, 1, 0, 3'b001, 1, 0, 0));
    apply("i_and",    1'b1, 7'b0010011, 3'b111, 1'b0, 1'b0, mk(1, 2'b00, 1, 0, 2'b00, 0, 0, 3'b010, 0, 0, 0));
    apply("i_addi",   1'b1, 7'b0010011, 3'b000, 1'b1, 1'b0, mk(1, 2'b00, 1, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0));
    apply("i_slti",   1'b1, 7'b0010011, 3'b010, 1'b0, 1'b0, mk(1, 2'b00, 1, 0, 2'b00, 0, 0, 3'b101, 0, 0, 0));
    apply("i_ori",    1'b1, 7'b0010011, 3'b110, 1'b1, 1'b1, mk(1, 2'b00, 1, 0, 2'b00, 0, 0, 3'b011, 0, 0, 0));
    apply("jal_z0",   1'b1, 7'b1101111, 3'b000, 1'b0, 1'b0, mk(1, 2'b11, 0, 0, 2'b10, 0, 1, 3'b000, 1, 0, 0));
    apply("jal_z1",   1'b1, 7'b1101111, 3'b010, 1'b1, 1'b1, mk(1, 2'b11, 0, 0, 2'b10, 0, 1, 3'b000, 1, 0, 0));
    // Illegal opcode: flag is combinational now, sticky only after the next edge.
    apply("ill_7f",   1'b1, 7'b1111111, 3'b000, 1'b1, 1'b1, mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 3'b000, 0, 1, 0));
    apply("stk_set",  1'b1, 7'b0110011, 3'b110, 1'b0, 1'b0, mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 3'b011, 0, 0, 1));
    apply("stk_hold", 1'b1, 7'b0110011, 3'b000, 1'b0, 1'b0, mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 1));
    // Reset asserted mid-cycle clears the flag before any further edge.
    apply("stk_rst",  1'b0, 7'b0110011, 3'b000, 1'b0, 1'b0, mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0));
    apply("rst_rel",  1'b1, 7'b0000011, 3'b000, 1'b0, 1'b0, mk(1, 2'b00, 1, 0, 2'b01, 0, 0, 3'b000, 0, 0, 0));
    // Another illegal (all zeros, also with branch-like zero=1) re-arms the flag.
    apply("ill_00",   1'b1, 7'b0000000, 3'b111, 1'b1, 1'b1, mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 3'b000, 0, 1, 0));
    apply("stk_set2", 1'b1, 7'b0100011, 3'b010, 1'b0, 1'b0, mk(0, 2'b01, 1, 1, 2'b00, 0, 0, 3'b000, 0, 0, 1));

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
